// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   data-access path. Each port uses a req/gnt/valid handshake. Only one
//   access is outstanding at a time. Data has priority, but a starvation
//   counter forces a fetch grant after STARVE_LIMIT consecutive data grants
//   that were issued while a fetch was waiting.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request
//   if_gnt/if_valid/if_instr       fetch accept pulse, completion pulse, instruction
//   d_req/d_rw/d_addr/d_wdata      data request (rw: 0 read, 1 write)
//   d_gnt/d_valid/d_rdata          data accept pulse, completion pulse, read data
//   mem_en/mem_rw/mem_addr/mem_wdata  memory strobe and command
//   mem_rdata                      memory read data, valid MEM_LAT cycles after mem_en
//   busy                           access outstanding
module mem_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1) + 1;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);
  localparam logic [SW-1:0]    S_MAX   = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic [DATA_W-1:0] if_instr_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              fetch_wins;

  assign fetch_wins = if_req && (!d_req || (starve_cnt == S_MAX));
  assign busy       = (state != IDLE);

  // mem_rdata is only valid in the completion cycle itself, so the data
  // outputs forward it during the valid pulse and hold a captured copy after.
  // mem_rw still holds the completed access's command in that cycle.
  assign if_instr = if_valid ? mem_rdata : if_instr_q;
  assign d_rdata  = (d_valid && !mem_rw) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_valid)             if_instr_q <= mem_rdata;
      if (d_valid && !mem_rw)   d_rdata_q  <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      mem_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            state      <= IF_WAIT;
            lat_cnt    <= LAT_W'(1);
            starve_cnt <= '0;
            if_gnt     <= 1'b1;
            mem_en     <= 1'b1;
            mem_rw     <= 1'b0;
            mem_addr   <= if_addr;
          end else if (d_req) begin
            state     <= D_WAIT;
            lat_cnt   <= LAT_W'(1);
            d_gnt     <= 1'b1;
            mem_en    <= 1'b1;
            mem_rw    <= d_rw;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != S_MAX)
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        IF_WAIT, D_WAIT: begin
          // Leaving WAIT one edge early puts the valid pulse and the IDLE
          // arbitration cycle together, giving MEM_LAT+1 cycles per access.
          if (lat_cnt == LAT_END) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            if_valid <= (state == IF_WAIT);
            d_valid  <= (state == D_WAIT);
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned L   = 1;
  localparam int unsigned LIM = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_instr;
  logic          d_req = 1'b0, d_rw = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_instr(if_instr),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    if (i == 0) return 32'h2008_0005;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Behavioural single-port memory with MEM_LAT-cycle read pipeline
  logic [DW-1:0] phys [32];
  logic [DW-1:0] rd_pipe [L];
  assign mem_rdata = rd_pipe[L-1];

  initial begin
    for (int i = 0; i < 32; i++) phys[i] <= init_word(i);
    for (int i = 0; i < int'(L); i++) rd_pipe[i] <= '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_rw) phys[mem_addr] <= mem_wdata;
    if (mem_en && !mem_rw) rd_pipe[0] <= phys[mem_addr];
    for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({if_gnt, if_valid, if_instr, d_gnt, d_valid, d_rdata, mem_en, mem_rw, mem_addr, mem_wdata, busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got gnt=%0b/%0b val=%0b/%0b en=%0b busy=%0b instr=%h rdata=%h addr=%0d expected all zero",
               if_gnt, d_gnt, if_valid, d_valid, mem_en, busy, if_instr, d_rdata, mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 5'd0;
    @(negedge clk);
    vecs++;
    if ({if_gnt, d_gnt, mem_en, mem_rw, mem_addr, busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1}) begin
      errs++;
      $display("FAIL fetch_grant got gnt=%0b dgnt=%0b en=%0b rw=%0b addr=%0d busy=%0b expected 1 0 1 0 0 1",
               if_gnt, d_gnt, mem_en, mem_rw, mem_addr, busy);
    end
    if_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({if_valid, if_instr, mem_en, busy} !== {1'b1, 32'h2008_0005, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL fetch_valid got val=%0b instr=%h en=%0b busy=%0b expected 1 20080005 0 0", if_valid, if_instr, mem_en, busy);
    end
    @(negedge clk);
    vecs++;
    if ({if_valid, if_instr} !== {1'b0, 32'h2008_0005}) begin
      errs++;
      $display("FAIL fetch_hold got val=%0b instr=%h expected 0 20080005", if_valid, if_instr);
    end
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_rw = 1'b1; d_addr = 5'd1; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vecs++;
    if ({d_gnt, if_gnt, mem_en, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'hDEAD_BEEF}) begin
      errs++;
      $display("FAIL write_grant got gnt=%0b en=%0b rw=%0b addr=%0d wdata=%h expected 1 1 1 1 deadbeef",
               d_gnt, mem_en, mem_rw, mem_addr, mem_wdata);
    end
    d_rw = 1'b0;
    @(negedge clk);
    vecs++;
    if ({d_valid, d_gnt, mem_en, d_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL write_done got val=%0b gnt=%0b en=%0b rdata=%h expected 1 0 0 00000000", d_valid, d_gnt, mem_en, d_rdata);
    end
    @(negedge clk);
    vecs++;
    if ({d_gnt, mem_en, mem_rw, mem_addr} !== {1'b1, 1'b1, 1'b0, 5'd1}) begin
      errs++;
      $display("FAIL read_grant got gnt=%0b en=%0b rw=%0b addr=%0d expected 1 1 0 1", d_gnt, mem_en, mem_rw, mem_addr);
    end
    d_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({d_valid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errs++;
      $display("FAIL read_data got val=%0b rdata=%h expected 1 deadbeef", d_valid, d_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [7:0] seq = '0;
    int n = 0, last = 0, cyc = 0;
    if_req = 1'b1; if_addr = 5'd7;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 5'd9;
    while (n < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_gnt && d_gnt) begin
        vecs++; errs++;
        $display("FAIL starve_overlap got both gnt high at cycle %0d expected one", cyc);
      end
      if (if_gnt || d_gnt) begin
        seq = {seq[6:0], if_gnt};
        if (n > 0) begin
          vecs++;
          if (cyc - last != int'(L) + 1) begin
            errs++;
            $display("FAIL starve_gap got %0d expected %0d", cyc - last, L + 1);
          end
        end
        last = cyc;
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    vecs++;
    if (n < 8) begin
      errs++;
      $display("FAIL starve_timeout got %0d grants expected 8", n);
    end
    vecs++;
    if (seq !== 8'b0001_0001) begin
      errs++;
      $display("FAIL starve_order got %b expected 00010001 (1=IF, oldest first)", seq);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_request();
    int en_cnt = 0;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 5'd3;
    @(negedge clk);
    en_cnt += int'(mem_en);
    vecs++;
    if (d_gnt !== 1'b1) begin errs++; $display("FAIL wait_first_gnt got %0b expected 1", d_gnt); end
    d_addr = 5'd4;
    @(negedge clk);
    en_cnt += int'(mem_en);
    vecs++;
    if ({d_gnt, d_valid, d_rdata} !== {1'b0, 1'b1, init_word(3)}) begin
      errs++;
      $display("FAIL wait_no_early_gnt got gnt=%0b val=%0b rdata=%h expected 0 1 %h", d_gnt, d_valid, d_rdata, init_word(3));
    end
    @(negedge clk);
    en_cnt += int'(mem_en);
    vecs++;
    if ({d_gnt, mem_addr} !== {1'b1, 5'd4}) begin
      errs++;
      $display("FAIL wait_second_gnt got gnt=%0b addr=%0d expected 1 4", d_gnt, mem_addr);
    end
    d_req = 1'b0;
    @(negedge clk);
    en_cnt += int'(mem_en);
    vecs++;
    if ({d_valid, d_rdata} !== {1'b1, init_word(4)}) begin
      errs++;
      $display("FAIL wait_second_data got val=%0b rdata=%h expected 1 %h", d_valid, d_rdata, init_word(4));
    end
    repeat (2) begin @(negedge clk); en_cnt += int'(mem_en); end
    vecs++;
    if (en_cnt != 2) begin errs++; $display("FAIL wait_mem_en_count got %0d expected 2", en_cnt); end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 5'd4;
    @(negedge clk);
    vecs++;
    if (if_gnt !== 1'b1) begin errs++; $display("FAIL rstmid_gnt got %0b expected 1", if_gnt); end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({mem_en, if_gnt, busy, mem_addr, if_instr} !== '0) begin
      errs++;
      $display("FAIL rstmid_async got en=%0b gnt=%0b busy=%0b addr=%0d instr=%h expected zeros", mem_en, if_gnt, busy, mem_addr, if_instr);
    end
    if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (if_valid !== 1'b0) begin errs++; $display("FAIL rstmid_no_valid got %0b expected 0", if_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 5'd2;
    @(negedge clk);
    vecs++;
    if ({if_gnt, mem_addr} !== {1'b1, 5'd2}) begin
      errs++;
      $display("FAIL rstmid_refetch_gnt got gnt=%0b addr=%0d expected 1 2", if_gnt, mem_addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({if_valid, if_instr} !== {1'b1, init_word(2)}) begin
      errs++;
      $display("FAIL rstmid_refetch_data got val=%0b instr=%h expected 1 %h", if_valid, if_instr, init_word(2));
    end
  endtask

  task automatic test_withdraw();
    if_req = 1'b1; if_addr = 5'd5;
    @(negedge clk);
    vecs++;
    if (if_gnt !== 1'b1) begin errs++; $display("FAIL withdraw_if_gnt got %0b expected 1", if_gnt); end
    if_req = 1'b0;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 5'd6; d_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 d_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({if_valid, if_instr, d_gnt} !== {1'b1, init_word(5), 1'b0}) begin
      errs++;
      $display("FAIL withdraw_fetch got val=%0b instr=%h dgnt=%0b expected 1 %h 0", if_valid, if_instr, d_gnt, init_word(5));
    end
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if ({d_gnt, mem_en, busy, if_instr} !== {1'b0, 1'b0, 1'b0, init_word(5)}) begin
        errs++;
        $display("FAIL withdraw_quiet got dgnt=%0b en=%0b busy=%0b instr=%h expected 0 0 0 %h", d_gnt, mem_en, busy, if_instr, init_word(5));
      end
    end
    vecs++;
    if (phys[6] !== init_word(6)) begin
      errs++;
      $display("FAIL withdraw_no_write got mem[6]=%h expected %h", phys[6], init_word(6));
    end
  endtask

  // Transaction-level reference: an access granted at the end of cycle c is
  // visible in c+1, completes in c+1+L, and the arbiter may decide again then.
  task automatic test_random();
    logic [DW-1:0] ref_mem [32];
    int ready = 0, gcyc = -1, vcyc = -1, starve = 0;
    bit gport = 1'b0, vport = 1'b0, vread = 1'b0;
    logic [DW-1:0] vdata = '0, e_wdata = '0, e_instr = '0, e_drd = '0;
    logic [AW-1:0] e_addr = '0;
    logic e_rw = 1'b0;
    bit e_ifg, e_dg, e_ifv, e_dv, e_busy, fw, dw;

    if_req = 1'b0; d_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = phys[i];

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      e_ifg  = (gcyc == c) && gport;
      e_dg   = (gcyc == c) && !gport;
      e_ifv  = (vcyc == c) && vport;
      e_dv   = (vcyc == c) && !vport;
      e_busy = (c < ready);
      if (e_ifv) e_instr = vdata;
      if (e_dv && vread) e_drd = vdata;

      vecs++;
      if ({if_gnt, d_gnt, if_valid, d_valid, mem_en, busy} !== {e_ifg, e_dg, e_ifv, e_dv, e_ifg | e_dg, e_busy}) begin
        errs++;
        $display("FAIL rnd_ctrl cyc %0d got gnt=%0b%0b val=%0b%0b en=%0b busy=%0b expected %0b%0b %0b%0b %0b %0b",
                 c, if_gnt, d_gnt, if_valid, d_valid, mem_en, busy, e_ifg, e_dg, e_ifv, e_dv, e_ifg | e_dg, e_busy);
      end
      vecs++;
      if ({mem_addr, mem_rw} !== {e_addr, e_rw}) begin
        errs++;
        $display("FAIL rnd_cmd cyc %0d got addr=%0d rw=%0b expected %0d %0b", c, mem_addr, mem_rw, e_addr, e_rw);
      end
      if (e_dg && e_rw) begin
        vecs++;
        if (mem_wdata !== e_wdata) begin
          errs++;
          $display("FAIL rnd_wdata cyc %0d got %h expected %h", c, mem_wdata, e_wdata);
        end
      end
      vecs++;
      if ({if_instr, d_rdata} !== {e_instr, e_drd}) begin
        errs++;
        $display("FAIL rnd_data cyc %0d got instr=%h rdata=%h expected %h %h", c, if_instr, d_rdata, e_instr, e_drd);
      end

      // Requesters: hold until granted, occasionally withdraw
      if (e_ifg) begin
        if_req = 1'($urandom_range(1, 0));
        if_addr = AW'($urandom);
      end else if (if_req) begin
        if ($urandom_range(9, 0) == 0) if_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom);
      end
      if (e_dg) begin
        d_req = 1'($urandom_range(1, 0));
        d_rw = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
      end else if (d_req) begin
        if ($urandom_range(9, 0) == 0) d_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        d_req = 1'b1; d_rw = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
      end

      if (c >= ready) begin
        fw = if_req && (!d_req || starve == int'(LIM));
        dw = d_req && !fw;
        if (fw) begin
          gport = 1'b1; e_addr = if_addr; e_rw = 1'b0;
          vdata = ref_mem[if_addr]; vread = 1'b1; starve = 0;
        end else if (dw) begin
          gport = 1'b0; e_addr = d_addr; e_rw = d_rw;
          if (d_rw) begin
            ref_mem[d_addr] = d_wdata; e_wdata = d_wdata; vread = 1'b0;
          end else begin
            vdata = ref_mem[d_addr]; vread = 1'b1;
          end
          starve = if_req ? ((starve < int'(LIM)) ? starve + 1 : int'(LIM)) : 0;
        end
        if (fw || dw) begin
          gcyc = c + 1; vcyc = c + 1 + int'(L); vport = gport; ready = c + 1 + int'(L);
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_starvation();
    test_wait_request();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
